// File: rtl/gal_ht_marker.sv
// rtl/gal_ht_marker.sv - head/tail marker with 2-entry skid buffer between user kernel and Galapagos router
module gal_ht_marker #(
  parameter int DATA_W    = 512,
  parameter int DEST_W    = 8,
  parameter int ID_W      = 8,
  parameter int IDX_W     = 5,
  parameter int MAX_BEATS = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                usr_tvalid,
  output logic                usr_tready,
  input  logic [DATA_W-1:0]   usr_tdata,
  input  logic [DATA_W/8-1:0] usr_tkeep,
  input  logic                usr_tlast,
  input  logic [DEST_W-1:0]   usr_tdest,
  input  logic [ID_W-1:0]     usr_tid,
  output logic                gal_tvalid,
  input  logic                gal_tready,
  output logic [DATA_W-1:0]   gal_tdata,
  output logic [DATA_W/8-1:0] gal_tkeep,
  output logic                gal_tlast,
  output logic [DEST_W-1:0]   gal_tdest,
  output logic [ID_W-1:0]     gal_tid,
  output logic [IDX_W+2:0]    gal_tuser,
  output logic [31:0]         pkt_count,
  output logic [15:0]         trunc_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int USER_W = IDX_W + 3;
  localparam int ENT_W  = DATA_W + KEEP_W + 1 + DEST_W + ID_W + USER_W;
  localparam int CNT_W  = 17;

  // Beat counter is wide enough for 2^16-beat packets; it saturates rather than wraps
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TRUNC_AT = (MAX_BEATS == 0) ? '0 : CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] IDX_SAT  = CNT_W'((1 << IDX_W) - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = '1;

  typedef enum logic {
    S_PASS,
    S_DROP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic              head_next;

  // Skid buffer: out_ent is the presented entry, skid_ent the second slot
  logic [ENT_W-1:0]  out_ent;
  logic [ENT_W-1:0]  skid_ent;
  logic              out_v;
  logic              skid_v;

  logic              acc;
  logic              push;
  logic              pop;
  logic              trunc;
  logic              in_last;
  logic [IDX_W-1:0]  idx;
  logic [USER_W-1:0] in_user;
  logic [ENT_W-1:0]  in_ent;
  logic [1:0]        occ;
  logic [1:0]        occ_next;

  // Beat marking and buffer bookkeeping for the current cycle
  always_comb begin
    acc        = usr_tvalid & usr_tready;
    push       = acc & (state == S_PASS);
    pop        = out_v & gal_tready;
    trunc      = (MAX_BEATS != 0) && (beat_cnt == TRUNC_AT) && !usr_tlast;
    in_last    = usr_tlast | trunc;
    idx        = (beat_cnt >= IDX_SAT) ? IDX_MAX : beat_cnt[IDX_W-1:0];
    in_user    = {idx, trunc, in_last, head_next};
    in_ent     = {usr_tdata, usr_tkeep, in_last, usr_tdest, usr_tid, in_user};
    occ        = 2'(out_v) + 2'(skid_v);
    occ_next   = occ + 2'(push) - 2'(pop);
    state_next = state;
    if (acc) begin
      if (state == S_PASS && trunc) begin
        state_next = S_DROP;
      end else if (state == S_DROP && usr_tlast) begin
        state_next = S_PASS;
      end
    end
  end

  // Two-entry skid buffer; the skid slot refills the output slot whenever it drains
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ent  <= '0;
      skid_ent <= '0;
      out_v    <= 1'b0;
      skid_v   <= 1'b0;
    end else if (!out_v || pop) begin
      if (skid_v) begin
        out_ent <= skid_ent;
        out_v   <= 1'b1;
        if (push) begin
          skid_ent <= in_ent;
        end
        skid_v <= push;
      end else begin
        if (push) begin
          out_ent <= in_ent;
        end
        out_v <= push;
      end
    end else if (push) begin
      skid_ent <= in_ent;
      skid_v   <= 1'b1;
    end
  end

  // PASS/DROP machine, beat counting, registered ready and statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PASS;
      beat_cnt    <= '0;
      head_next   <= 1'b1;
      usr_tready  <= 1'b0;
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      state      <= state_next;
      usr_tready <= (occ_next < 2'd2) || (state_next == S_DROP);
      if (acc) begin
        if (state == S_PASS) begin
          if (trunc || usr_tlast) begin
            beat_cnt  <= '0;
            head_next <= 1'b1;
          end else begin
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            head_next <= 1'b0;
          end
          if (trunc && trunc_count != 16'hFFFF) begin
            trunc_count <= trunc_count + 1'b1;
          end
        end else if (usr_tlast) begin
          beat_cnt  <= '0;
          head_next <= 1'b1;
        end
      end
      if (pop && gal_tlast) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  assign gal_tvalid = out_v;
  assign {gal_tdata, gal_tkeep, gal_tlast, gal_tdest, gal_tid, gal_tuser} = out_ent;

endmodule

// File: tb/tb_gal_ht_marker.sv
// tb/tb_gal_ht_marker.sv - scoreboard bench for gal_ht_marker (unlimited and 4-beat-limited instances)
module tb_gal_ht_marker;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  dest;
    logic [7:0]  id;
    logic [7:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance a: MAX_BEATS=0, instance b: MAX_BEATS=4
  logic        usr_tvalid_a, usr_tready_a, usr_tlast_a;
  logic [63:0] usr_tdata_a;
  logic [7:0]  usr_tkeep_a, usr_tdest_a, usr_tid_a;
  logic        gal_tvalid_a, gal_tready_a, gal_tlast_a;
  logic [63:0] gal_tdata_a;
  logic [7:0]  gal_tkeep_a, gal_tdest_a, gal_tid_a, gal_tuser_a;
  logic [31:0] pkt_count_a;
  logic [15:0] trunc_count_a;

  logic        usr_tvalid_b, usr_tready_b, usr_tlast_b;
  logic [63:0] usr_tdata_b;
  logic [7:0]  usr_tkeep_b, usr_tdest_b, usr_tid_b;
  logic        gal_tvalid_b, gal_tready_b, gal_tlast_b;
  logic [63:0] gal_tdata_b;
  logic [7:0]  gal_tkeep_b, gal_tdest_b, gal_tid_b, gal_tuser_b;
  logic [31:0] pkt_count_b;
  logic [15:0] trunc_count_b;

  gal_ht_marker #(.DATA_W(64), .DEST_W(8), .ID_W(8), .IDX_W(5), .MAX_BEATS(0)) dut_a (
    .clk(clk), .reset(reset),
    .usr_tvalid(usr_tvalid_a), .usr_tready(usr_tready_a), .usr_tdata(usr_tdata_a),
    .usr_tkeep(usr_tkeep_a), .usr_tlast(usr_tlast_a), .usr_tdest(usr_tdest_a), .usr_tid(usr_tid_a),
    .gal_tvalid(gal_tvalid_a), .gal_tready(gal_tready_a), .gal_tdata(gal_tdata_a),
    .gal_tkeep(gal_tkeep_a), .gal_tlast(gal_tlast_a), .gal_tdest(gal_tdest_a), .gal_tid(gal_tid_a),
    .gal_tuser(gal_tuser_a), .pkt_count(pkt_count_a), .trunc_count(trunc_count_a)
  );

  gal_ht_marker #(.DATA_W(64), .DEST_W(8), .ID_W(8), .IDX_W(5), .MAX_BEATS(4)) dut_b (
    .clk(clk), .reset(reset),
    .usr_tvalid(usr_tvalid_b), .usr_tready(usr_tready_b), .usr_tdata(usr_tdata_b),
    .usr_tkeep(usr_tkeep_b), .usr_tlast(usr_tlast_b), .usr_tdest(usr_tdest_b), .usr_tid(usr_tid_b),
    .gal_tvalid(gal_tvalid_b), .gal_tready(gal_tready_b), .gal_tdata(gal_tdata_b),
    .gal_tkeep(gal_tkeep_b), .gal_tlast(gal_tlast_b), .gal_tdest(gal_tdest_b), .gal_tid(gal_tid_b),
    .gal_tuser(gal_tuser_b), .pkt_count(pkt_count_b), .trunc_count(trunc_count_b)
  );

  beat_t q_a[$];
  beat_t q_b[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    mon_en = 1'b1;
  logic [3:0] pat_a = 4'hF;
  logic [3:0] pat_b = 4'hF;
  int    xfer_a = 0;
  int    first_a = 0;
  int    last_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tuser = {idx[4:0], truncated, tail, head}
  function automatic logic [7:0] mk(input int idx, input bit tr, input bit tl, input bit hd);
    return {idx[4:0], tr, tl, hd};
  endfunction

  // Drive one beat, queue its expected output if it should be forwarded, wait for acceptance
  task automatic send(input bit b, input logic [63:0] data, input logic last,
                      input logic [7:0] dest, input bit fwd, input logic [7:0] user);
    beat_t e;
    bit    got;
    e.data = data;
    e.keep = data[15:8];
    e.last = last | user[2];
    e.dest = dest;
    e.id   = data[7:0];
    e.user = user;
    if (!b) begin
      usr_tvalid_a = 1'b1; usr_tdata_a = data; usr_tkeep_a = data[15:8];
      usr_tlast_a = last; usr_tdest_a = dest; usr_tid_a = data[7:0];
      if (fwd) q_a.push_back(e);
    end else begin
      usr_tvalid_b = 1'b1; usr_tdata_b = data; usr_tkeep_b = data[15:8];
      usr_tlast_b = last; usr_tdest_b = dest; usr_tid_b = data[7:0];
      if (fwd) q_b.push_back(e);
    end
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = b ? usr_tready_b : usr_tready_a;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: usr_tready got 0 expected 1 on dut %0d", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit b);
    if (!b) usr_tvalid_a = 1'b0;
    else    usr_tvalid_b = 1'b0;
  endtask

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output ready patterns, applied just after each rising edge
  initial begin
    gal_tready_a = 1'b0;
    gal_tready_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gal_tready_a = pat_a[0];
      pat_a = {pat_a[0], pat_a[3:1]};
      gal_tready_b = pat_b[0];
      pat_b = {pat_b[0], pat_b[3:1]};
    end
  end

  // Monitors: every presented beat must equal the queue head; pop on transfer
  initial begin
    beat_t act;
    forever begin
      @(negedge clk);
      if (mon_en && gal_tvalid_a) begin
        act = {gal_tdata_a, gal_tkeep_a, gal_tlast_a, gal_tdest_a, gal_tid_a, gal_tuser_a};
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_a_unexpected: got %0h expected no beat", act);
        end else begin
          chk("out_a_beat", 128'(act), 128'(q_a[0]));
          if (gal_tready_a) begin
            void'(q_a.pop_front());
            if (xfer_a == 0) first_a = cyc;
            last_a = cyc;
            xfer_a++;
          end
        end
      end
      if (mon_en && gal_tvalid_b) begin
        act = {gal_tdata_b, gal_tkeep_b, gal_tlast_b, gal_tdest_b, gal_tid_b, gal_tuser_b};
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_b_unexpected: got %0h expected no beat", act);
        end else begin
          chk("out_b_beat", 128'(act), 128'(q_b[0]));
          if (gal_tready_b) void'(q_b.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    usr_tvalid_a = 0; usr_tdata_a = '0; usr_tkeep_a = '0; usr_tlast_a = 0; usr_tdest_a = '0; usr_tid_a = '0;
    usr_tvalid_b = 0; usr_tdata_b = '0; usr_tkeep_b = '0; usr_tlast_b = 0; usr_tdest_b = '0; usr_tid_b = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gal_tvalid", 128'(gal_tvalid_a), 128'(0));
    chk("rst_usr_tready", 128'(usr_tready_a), 128'(0));
    chk("rst_pkt_count", 128'(pkt_count_a), 128'(0));
    chk("rst_trunc_count", 128'(trunc_count_b), 128'(0));
    chk("rst_gal_fields", {gal_tdata_a, gal_tuser_a, gal_tdest_a}, 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    waitc(1);
    chk("ready_after_reset", 128'(usr_tready_a), 128'(1));

    // Single-beat packet, one-cycle latency
    send(0, {8{8'hA5}}, 1, 8'd3, 1, mk(0, 0, 1, 1));
    idle(0);
    chk("single_latency_valid", 128'(gal_tvalid_a), 128'(1));
    chk("single_tdest", 128'(gal_tdest_a), 128'(3));
    waitc(2);
    chk("single_pkt_count", 128'(pkt_count_a), 128'(1));

    // 3-beat packet: fill both slots with output stalled, then toggle ready
    pat_a = 4'h0;
    waitc(2);
    send(0, 64'h1111_0000_0000_2201, 0, 8'd4, 1, mk(0, 0, 0, 1));
    send(0, 64'h2222_0000_0000_3302, 0, 8'd5, 1, mk(1, 0, 0, 0));
    idle(0);
    @(negedge clk);
    chk("stall_usr_tready_low", 128'(usr_tready_a), 128'(0));
    @(posedge clk);
    #1;
    pat_a = 4'b1001;
    send(0, 64'h3333_0000_0000_4403, 1, 8'd6, 1, mk(2, 0, 1, 0));
    idle(0);
    waitc(10);
    chk("stall_pkt_count", 128'(pkt_count_a), 128'(2));

    // Five back-to-back 2-beat packets at full rate
    pat_a = 4'hF;
    waitc(3);
    xfer_a = 0;
    c0 = cyc;
    for (int p = 0; p < 5; p++) begin
      send(0, 64'h5000_0000_0000_FF10 + 64'(2 * p), 0, 8'(p), 1, mk(0, 0, 0, 1));
      send(0, 64'h5000_0000_0000_FF11 + 64'(2 * p), 1, 8'(p), 1, mk(1, 0, 1, 0));
    end
    c1 = cyc;
    idle(0);
    chk("b2b_input_cycles", 128'(c1 - c0), 128'(10));
    waitc(3);
    chk("b2b_output_beats", 128'(xfer_a), 128'(10));
    chk("b2b_output_span", 128'(last_a - first_a), 128'(9));
    chk("b2b_pkt_count", 128'(pkt_count_a), 128'(7));

    // 40-beat packet with no length limit: index saturates at 31
    for (int i = 0; i < 40; i++) begin
      send(0, 64'h4000_0000_0000_0F00 + 64'(i), (i == 39), 8'h40, 1,
           mk((i < 31) ? i : 31, 0, (i == 39), (i == 0)));
    end
    idle(0);
    waitc(3);
    chk("long_pkt_count", 128'(pkt_count_a), 128'(8));
    chk("long_no_trunc", 128'(trunc_count_a), 128'(0));

    // MAX_BEATS=4: 6-beat packet truncated after beat 3, beats 4-5 dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 3)
        send(1, 64'h6000_0000_0000_AA00 + 64'(i), (i == 5), 8'h21, 1, mk(i, 0, 0, (i == 0)));
      else
        send(1, 64'h6000_0000_0000_AA00 + 64'(i), (i == 5), 8'h21, (i == 3), mk(3, 1, 1, 0));
    end
    idle(1);
    waitc(3);
    chk("trunc_pkt_count", 128'(pkt_count_b), 128'(1));
    chk("trunc_count", 128'(trunc_count_b), 128'(1));
    send(1, 64'h7000_0000_0000_BB00, 1, 8'h22, 1, mk(0, 0, 1, 1));
    for (int i = 0; i < 4; i++) begin
      send(1, 64'h8000_0000_0000_CC00 + 64'(i), (i == 3), 8'h23, 1, mk(i, 0, (i == 3), (i == 0)));
    end
    idle(1);
    waitc(3);
    chk("exact_len_pkt_count", 128'(pkt_count_b), 128'(3));
    chk("exact_len_no_trunc", 128'(trunc_count_b), 128'(1));

    // Reset mid-packet with two beats buffered
    pat_a = 4'h0;
    waitc(2);
    send(0, 64'h9000_0000_0000_DD00, 0, 8'h30, 1, mk(0, 0, 0, 1));
    send(0, 64'h9000_0000_0000_DD01, 0, 8'h30, 1, mk(1, 0, 0, 0));
    idle(0);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_a.delete();
    q_b.delete();
    chk("midrst_gal_tvalid", 128'(gal_tvalid_a), 128'(0));
    chk("midrst_usr_tready", 128'(usr_tready_a), 128'(0));
    chk("midrst_pkt_count", 128'(pkt_count_a), 128'(0));
    chk("midrst_trunc_count", 128'(trunc_count_b), 128'(0));
    mon_en = 1'b1;
    pat_a = 4'hF;
    send(0, 64'hA000_0000_0000_EE00, 0, 8'h31, 1, mk(0, 0, 0, 1));
    send(0, 64'hA000_0000_0000_EE01, 1, 8'h32, 1, mk(1, 0, 1, 0));
    idle(0);
    waitc(4);
    chk("postrst_pkt_count", 128'(pkt_count_a), 128'(1));
    chk("drained_a", 128'(q_a.size()), 128'(0));
    chk("drained_b", 128'(q_b.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gal_ht_marker.md
Name: gal_ht_marker

Overview:
- Parametrised head/tail marker between a user AXI-Stream kernel port and the Galapagos router stream.
- Registers the stream through a 2-entry skid buffer.
- Fills gal_tuser with head, tail, truncation and beat-index fields.
- Optionally enforces a maximum packet length (truncate and drop), and exports packet and truncation counters.

Parameters:
- DATA_W, 512, tdata width in bits; tkeep width is DATA_W/8.
- DEST_W, 8, tdest width.
- ID_W, 8, tid width.
- IDX_W, 5, beat-index field width in tuser; gal_tuser width is IDX_W+3.
- MAX_BEATS, 0, maximum beats per packet; 0 disables enforcement; legal range 0 or 2..2^16.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- usr_tvalid  in  1  user beat valid
- usr_tready  out  1  user beat ready
- usr_tdata  in  DATA_W  user data
- usr_tkeep  in  DATA_W/8  user byte enables
- usr_tlast  in  1  user end of packet
- usr_tdest  in  DEST_W  destination kernel
- usr_tid  in  ID_W  source kernel
- gal_tvalid  out  1  output beat valid
- gal_tready  in  1  output ready
- gal_tdata  out  DATA_W  output data
- gal_tkeep  out  DATA_W/8  output byte enables
- gal_tlast  out  1  output end of packet; forced on truncation
- gal_tdest  out  DEST_W  output destination
- gal_tid  out  ID_W  output source
- gal_tuser  out  IDX_W+3  bit0 head, bit1 tail, bit2 truncated, [IDX_W+2:3] beat index
- pkt_count  out  32  packets emitted (tail handshakes), wraps
- trunc_count  out  16  packets truncated, saturates at 0xFFFF

Behaviour:
- Reset (synchronous, high):
  - Skid buffer emptied; gal_tvalid=0; all gal_* data fields 0.
  - usr_tready=0 during reset, 1 on the first cycle after.
  - State PASS; beat index 0; next beat is head; pkt_count=0; trunc_count=0.
  - Reset mid-packet discards all buffered and in-flight beats; no tail is emitted for them.
- Handshake:
  - Input accepted when usr_tvalid & usr_tready; output transfers when gal_tvalid & gal_tready.
  - usr_tready is registered: 1 when the buffer holds fewer than 2 entries, or in DROP state.
  - Latency: a beat accepted in cycle N is presented on gal_* in cycle N+1 if the buffer was empty.
  - Sustained throughput is 1 beat/cycle with gal_tready held high.
  - Output fields stay stable while gal_tvalid=1 and gal_tready=0.
  - Ordering is strictly FIFO.
- Marking (computed at input acceptance, stored with the beat):
  - head=1 on the first accepted beat after reset or after any forwarded beat with tail=1.
  - tail = forwarded tlast.
  - index = beat number within the packet, starting at 0 and saturating at 2^IDX_W-1.
  - A single-beat packet has head=1 and tail=1.
- State machine:
  - PASS: forward each accepted beat.
    - If MAX_BEATS≠0, the beat count reaches MAX_BEATS-1 and usr_tlast=0: forward with tlast=1, tail=1, truncated=1; increment trunc_count; go to DROP.
    - Otherwise the index increments, or resets to 0 on tlast.
  - DROP: usr_tready=1; accepted beats are discarded, not buffered.
    - A beat with usr_tlast=1 returns the machine to PASS; the next beat is head.
- Boundaries:
  - A packet of exactly MAX_BEATS beats is not truncated.
  - The index field saturates independently of MAX_BEATS.
  - pkt_count increments on every output transfer with gal_tlast=1, including truncated packets; it wraps 0xFFFFFFFF→0.
  - tdest/tid are per-beat passthrough and are not latched from the head.
  - Simultaneous input accept and output transfer with one entry buffered: occupancy unchanged.

Test Plan:
- Single beat, tdata=0xA5.., tlast=1, tdest=3 → next cycle gal_tuser head=1, tail=1, idx=0, gal_tdest=3; pkt_count=1.
- 3-beat packet with gal_tready toggling 1,0,0,1… → usr_tready falls after 2 beats are buffered; output order preserved; idx 0,1,2; head only on beat0, tail only on beat2; outputs stable while stalled.
- MAX_BEATS=4, 6-beat input → 4 beats out, beat3 gal_tlast=1 with truncated=1; beats 4–5 accepted and dropped; next packet's first beat has head=1; trunc_count=1, pkt_count=1.
- 5 back-to-back 2-beat packets, gal_tready=1 → 10 output beats in 10 consecutive cycles; pkt_count=5.
- MAX_BEATS=0, 40-beat packet with IDX_W=5 → idx 0..31, then 31 for beats 32–39; no truncation.
- reset asserted for 1 cycle after beat1 of a 4-beat packet, with 2 beats buffered → gal_tvalid=0 the next cycle; the next accepted beat has head=1, idx=0; pkt_count=0.
